stack_tos_sequencer: RTL and testbench
======================================

STACK_TOS_SEQUENCER -- requirements
Module: stack_tos_sequencer

Interface
REQ-001 SHALL have parameter: ADDR_WIDTH, 12, width of TOS and stack address.
REQ-002 SHALL have ports clk  in  1  rising-edge clock; reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports cmd_valid  in  1  command offered; cmd_op  in  3  opcode; cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-004 SHALL have port ret_tos  in  ADDR_WIDTH  value the datapath loads on TOS restore (same net as datapath MUX_TOS_IN_1).
REQ-005 SHALL have ports done  out  1  one-cycle completion pulse; err  out  1  one-cycle overflow/underflow pulse; tos_shadow  out  ADDR_WIDTH  controller copy of TOS.
REQ-006 SHALL drive these datapath controls: SEL_MUX_STACK  out  3; CTRL_REG_READ_STACK, CTRL_REG_WRITE_STACK, CTRL_REG_READ_MEM, CTRL_REG_WRITE_MEM, SEL_MUX_TOS, CTRL_REG_TOS, SEL_TOS_UPDATER, CTRL_STACK, CTRL_MEM_EXT  out  1 each.

Function
REQ-007 SHALL implement a Moore FSM: IDLE, MEM_RD, MEM_CAP, POP_RD, POP_CAP, PUSH_LD, PUSH_WR, ST_LD, ST_WR, RESTORE, ERR; every non-IDLE state lasts exactly one cycle.
REQ-008 cmd_ready SHALL be high only in IDLE (and reset released); a command is accepted on a clock edge with cmd_valid&cmd_ready; cmd_op is latched at acceptance; cmd_valid outside IDLE is ignored.
REQ-009 Opcodes SHALL be: 000 PUSH_ALU, 001 PUSH_MEM, 010 PUSH_RET, 011 PUSH_ARG, 100 DUP, 101 POP, 110 POP_STORE, 111 RESTORE_TOS.
REQ-010 State sequences after acceptance SHALL be: PUSH_ALU/RET/ARG: PUSH_LD,PUSH_WR; PUSH_MEM: MEM_RD,MEM_CAP,PUSH_LD,PUSH_WR; DUP: POP_RD,POP_CAP,PUSH_LD,PUSH_WR; POP: POP_RD,POP_CAP; POP_STORE: POP_RD,POP_CAP,ST_LD,ST_WR; RESTORE_TOS: RESTORE; then IDLE.
REQ-011 All controls SHALL be 0 (SEL_MUX_STACK=000) except as listed per state.
REQ-012 PUSH_LD SHALL assert CTRL_REG_WRITE_STACK, CTRL_REG_TOS, SEL_TOS_UPDATER=1 (TOS+1), SEL_MUX_TOS=0, SEL_MUX_STACK = 000/001/010/011/100 for ALU/MEM/RET/ARG/DUP.
REQ-013 PUSH_WR SHALL assert CTRL_STACK.
REQ-014 MEM_RD SHALL assert nothing (read wait); MEM_CAP SHALL assert CTRL_REG_READ_MEM.
REQ-015 POP_RD SHALL assert nothing; POP_CAP SHALL assert CTRL_REG_READ_STACK, and for POP/POP_STORE additionally CTRL_REG_TOS with SEL_TOS_UPDATER=0 (TOS-1); for DUP no TOS change.
REQ-016 ST_LD SHALL assert CTRL_REG_WRITE_MEM; ST_WR SHALL assert CTRL_MEM_EXT.
REQ-017 RESTORE SHALL assert SEL_MUX_TOS=1 and CTRL_REG_TOS, and load tos_shadow <= ret_tos.
REQ-018 tos_shadow SHALL increment on PUSH_LD and decrement on POP_CAP when TOS changes, tracking datapath REG_TOS exactly.
REQ-019 done SHALL be high during the last state of each sequence (PUSH_WR, POP_CAP for POP, ST_WR, RESTORE, ERR).
REQ-020 Overflow: push-class op (000-100) accepted with tos_shadow = all ones SHALL go to ERR instead of its sequence; no datapath control asserted.
REQ-021 Underflow: POP, POP_STORE or DUP accepted with tos_shadow = 0 SHALL go to ERR; DUP at all ones SHALL be overflow; underflow checked first.
REQ-022 ERR SHALL assert err and done together for one cycle, leave tos_shadow unchanged, and return to IDLE.
REQ-023 RESTORE_TOS SHALL never error.

Reset
REQ-024 reset low SHALL immediately force IDLE, tos_shadow=0, done=0, err=0, all controls 0, cmd_ready=0, including mid-sequence; partial sequences are abandoned.
REQ-025 After reset rises, cmd_ready SHALL be 1 from the next clock edge.

Verification
REQ-026 Reset, PUSH_ALU -> cmd_ready low 2 cycles; PUSH_LD shows SEL_MUX_STACK=000, CTRL_REG_TOS=1, SEL_TOS_UPDATER=1; PUSH_WR CTRL_STACK=1, done=1; tos_shadow=1.
REQ-027 After three pushes, POP_STORE -> POP_CAP (CTRL_REG_READ_STACK, TOS-1), ST_LD, ST_WR CTRL_MEM_EXT=1 with done; tos_shadow=2; total 4 cycles.
REQ-028 POP at tos_shadow=0 -> err=1 and done=1 in the cycle after acceptance, zero controls, tos_shadow stays 0.
REQ-029 RESTORE_TOS with ret_tos=0xFFF then PUSH_ARG -> tos_shadow=0xFFF, push yields err, no CTRL_STACK; DUP also yields err.
REQ-030 PUSH_MEM with reset pulled low during MEM_CAP -> all outputs 0 asynchronously, tos_shadow=0, next command accepted normally.

Source files
------------

// File: rtl/stack_tos_sequencer.sv
// Stack/TOS controller: Moore FSM sequencing the stack datapath for push, pop,
// store and TOS-restore commands, keeping a shadow copy of TOS for bound checks.
module stack_tos_sequencer #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    input  logic [2:0]            cmd_op,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] ret_tos,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] tos_shadow,
    output logic [2:0]            SEL_MUX_STACK,
    output logic                  CTRL_REG_READ_STACK,
    output logic                  CTRL_REG_WRITE_STACK,
    output logic                  CTRL_REG_READ_MEM,
    output logic                  CTRL_REG_WRITE_MEM,
    output logic                  SEL_MUX_TOS,
    output logic                  CTRL_REG_TOS,
    output logic                  SEL_TOS_UPDATER,
    output logic                  CTRL_STACK,
    output logic                  CTRL_MEM_EXT,
    output logic [3:0]            state_dbg
);

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready is high only in IDLE once out of reset.

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_MEM_RD  = 4'd1,
        S_MEM_CAP = 4'd2,
        S_POP_RD  = 4'd3,
        S_POP_CAP = 4'd4,
        S_PUSH_LD = 4'd5,
        S_PUSH_WR = 4'd6,
        S_ST_LD   = 4'd7,
        S_ST_WR   = 4'd8,
        S_RESTORE = 4'd9,
        S_ERR     = 4'd10
    } state_t;

    localparam logic [2:0] OP_PUSH_ALU    = 3'b000;
    localparam logic [2:0] OP_PUSH_MEM    = 3'b001;
    localparam logic [2:0] OP_PUSH_RET    = 3'b010;
    localparam logic [2:0] OP_PUSH_ARG    = 3'b011;
    localparam logic [2:0] OP_DUP         = 3'b100;
    localparam logic [2:0] OP_POP         = 3'b101;
    localparam logic [2:0] OP_POP_STORE   = 3'b110;
    localparam logic [2:0] OP_RESTORE_TOS = 3'b111;

    localparam logic [ADDR_WIDTH-1:0] TOS_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] TOS_FULL = '1;

    state_t     state, state_nxt;
    logic [2:0] op_q;
    logic       started;
    logic       accept;
    logic       underflow;
    logic       overflow;

    assign cmd_ready = (state == S_IDLE) && started;
    assign accept    = cmd_valid && cmd_ready;
    assign state_dbg = state;

    // Underflow takes priority, so DUP on an empty stack reports underflow.
    assign underflow = ((cmd_op == OP_POP) || (cmd_op == OP_POP_STORE) || (cmd_op == OP_DUP))
                       && (tos_shadow == '0);
    assign overflow  = (cmd_op <= OP_DUP) && (tos_shadow == TOS_FULL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            op_q       <= OP_PUSH_ALU;
            started    <= 1'b0;
            tos_shadow <= '0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
            if (accept) begin
                op_q <= cmd_op;
            end
            case (state)
                S_PUSH_LD: tos_shadow <= tos_shadow + TOS_ONE;
                S_POP_CAP: if (op_q != OP_DUP) tos_shadow <= tos_shadow - TOS_ONE;
                S_RESTORE: tos_shadow <= ret_tos;
                default:   tos_shadow <= tos_shadow;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (underflow || overflow) begin
                        state_nxt = S_ERR;
                    end else begin
                        case (cmd_op)
                            OP_PUSH_MEM:                 state_nxt = S_MEM_RD;
                            OP_DUP, OP_POP, OP_POP_STORE: state_nxt = S_POP_RD;
                            OP_RESTORE_TOS:              state_nxt = S_RESTORE;
                            default:                     state_nxt = S_PUSH_LD;
                        endcase
                    end
                end
            end
            S_MEM_RD:  state_nxt = S_MEM_CAP;
            S_MEM_CAP: state_nxt = S_PUSH_LD;
            S_POP_RD:  state_nxt = S_POP_CAP;
            S_POP_CAP: begin
                case (op_q)
                    OP_DUP:       state_nxt = S_PUSH_LD;
                    OP_POP_STORE: state_nxt = S_ST_LD;
                    default:      state_nxt = S_IDLE;
                endcase
            end
            S_PUSH_LD: state_nxt = S_PUSH_WR;
            S_PUSH_WR: state_nxt = S_IDLE;
            S_ST_LD:   state_nxt = S_ST_WR;
            S_ST_WR:   state_nxt = S_IDLE;
            S_RESTORE: state_nxt = S_IDLE;
            S_ERR:     state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        SEL_MUX_STACK        = 3'b000;
        CTRL_REG_READ_STACK  = 1'b0;
        CTRL_REG_WRITE_STACK = 1'b0;
        CTRL_REG_READ_MEM    = 1'b0;
        CTRL_REG_WRITE_MEM   = 1'b0;
        SEL_MUX_TOS          = 1'b0;
        CTRL_REG_TOS         = 1'b0;
        SEL_TOS_UPDATER      = 1'b0;
        CTRL_STACK           = 1'b0;
        CTRL_MEM_EXT         = 1'b0;
        done                 = 1'b0;
        err                  = 1'b0;
        case (state)
            S_PUSH_LD: begin
                // Push opcodes 000..100 coincide with the stack mux source select.
                SEL_MUX_STACK        = op_q;
                CTRL_REG_WRITE_STACK = 1'b1;
                CTRL_REG_TOS         = 1'b1;
                SEL_TOS_UPDATER      = 1'b1;
            end
            S_PUSH_WR: begin
                CTRL_STACK = 1'b1;
                done       = 1'b1;
            end
            S_MEM_CAP: CTRL_REG_READ_MEM = 1'b1;
            S_POP_CAP: begin
                CTRL_REG_READ_STACK = 1'b1;
                CTRL_REG_TOS        = (op_q != OP_DUP);
                done                = (op_q == OP_POP);
            end
            S_ST_LD:   CTRL_REG_WRITE_MEM = 1'b1;
            S_ST_WR: begin
                CTRL_MEM_EXT = 1'b1;
                done         = 1'b1;
            end
            S_RESTORE: begin
                SEL_MUX_TOS  = 1'b1;
                CTRL_REG_TOS = 1'b1;
                done         = 1'b1;
            end
            S_ERR: begin
                err  = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_tos_sequencer.sv
// Directed bench for stack_tos_sequencer: walks each command sequence cycle by
// cycle and compares controls, done/err, cmd_ready and tos_shadow to hand values.
module tb_stack_tos_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic        cmd_ready;
    logic [11:0] ret_tos;
    logic        done;
    logic        err;
    logic [11:0] tos_shadow;
    logic [2:0]  SEL_MUX_STACK;
    logic        CTRL_REG_READ_STACK, CTRL_REG_WRITE_STACK, CTRL_REG_READ_MEM;
    logic        CTRL_REG_WRITE_MEM, SEL_MUX_TOS, CTRL_REG_TOS, SEL_TOS_UPDATER;
    logic        CTRL_STACK, CTRL_MEM_EXT;
    logic [3:0]  state_dbg;
    logic [11:0] ctrl;

    int checks = 0;
    int errors = 0;

    stack_tos_sequencer #(.ADDR_WIDTH(12)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .ret_tos(ret_tos), .done(done), .err(err), .tos_shadow(tos_shadow),
        .SEL_MUX_STACK(SEL_MUX_STACK),
        .CTRL_REG_READ_STACK(CTRL_REG_READ_STACK),
        .CTRL_REG_WRITE_STACK(CTRL_REG_WRITE_STACK),
        .CTRL_REG_READ_MEM(CTRL_REG_READ_MEM),
        .CTRL_REG_WRITE_MEM(CTRL_REG_WRITE_MEM),
        .SEL_MUX_TOS(SEL_MUX_TOS), .CTRL_REG_TOS(CTRL_REG_TOS),
        .SEL_TOS_UPDATER(SEL_TOS_UPDATER), .CTRL_STACK(CTRL_STACK),
        .CTRL_MEM_EXT(CTRL_MEM_EXT), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // [11:9] SEL_MUX_STACK, [8] RD_STK, [7] WR_STK, [6] RD_MEM, [5] WR_MEM,
    // [4] SEL_MUX_TOS, [3] REG_TOS, [2] TOS_UPD, [1] STACK, [0] MEM_EXT
    assign ctrl = {SEL_MUX_STACK, CTRL_REG_READ_STACK, CTRL_REG_WRITE_STACK,
                   CTRL_REG_READ_MEM, CTRL_REG_WRITE_MEM, SEL_MUX_TOS, CTRL_REG_TOS,
                   SEL_TOS_UPDATER, CTRL_STACK, CTRL_MEM_EXT};

    localparam logic [11:0] C_NONE    = 12'h000;
    localparam logic [11:0] C_LD_ALU  = 12'h08C;
    localparam logic [11:0] C_LD_MEM  = 12'h28C;
    localparam logic [11:0] C_LD_RET  = 12'h48C;
    localparam logic [11:0] C_LD_DUP  = 12'h88C;
    localparam logic [11:0] C_WR      = 12'h002;
    localparam logic [11:0] C_MEM_CAP = 12'h040;
    localparam logic [11:0] C_POP_CAP = 12'h108;
    localparam logic [11:0] C_DUP_CAP = 12'h100;
    localparam logic [11:0] C_ST_LD   = 12'h020;
    localparam logic [11:0] C_ST_WR   = 12'h001;
    localparam logic [11:0] C_RESTORE = 12'h018;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a command, wait (bounded) for acceptance, leave bench in first state.
    task automatic issue(input logic [2:0] op);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        while (!cmd_ready && n < 10) begin
            tick();
            n++;
        end
        chk("ready_before_issue", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic cyc(input string tag, input logic [11:0] c, input logic d,
                       input logic e, input logic [11:0] t);
        chk({tag, ".ctrl"}, 32'(ctrl), 32'(c));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".err"},  32'(err),  32'(e));
        chk({tag, ".tos"},  32'(tos_shadow), 32'(t));
        chk({tag, ".rdy"},  32'(cmd_ready), 32'd0);
        tick();
    endtask

    task automatic idle(input string tag, input logic [11:0] t);
        chk({tag, ".idle_ctrl"}, 32'(ctrl), 32'(C_NONE));
        chk({tag, ".idle_done"}, 32'(done), 32'd0);
        chk({tag, ".idle_tos"},  32'(tos_shadow), 32'(t));
        chk({tag, ".idle_rdy"},  32'(cmd_ready), 32'd1);
    endtask

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        ret_tos   = 12'h000;
        tick();
        chk("rst.rdy",  32'(cmd_ready), 32'd0);
        chk("rst.ctrl", 32'(ctrl), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err",  32'(err), 32'd0);
        chk("rst.tos",  32'(tos_shadow), 32'd0);
        chk("rst.state", 32'(state_dbg), 32'd0);
        tick();
        reset = 1'b1;
        chk("rel.rdy_low", 32'(cmd_ready), 32'd0);
        tick();
        chk("rel.rdy_high", 32'(cmd_ready), 32'd1);

        // PUSH_ALU
        issue(3'b000);
        cyc("alu.ld", C_LD_ALU, 1'b0, 1'b0, 12'd0);
        cyc("alu.wr", C_WR,     1'b1, 1'b0, 12'd1);
        idle("alu", 12'd1);

        // PUSH_MEM
        issue(3'b001);
        cyc("mem.rd",  C_NONE,    1'b0, 1'b0, 12'd1);
        cyc("mem.cap", C_MEM_CAP, 1'b0, 1'b0, 12'd1);
        cyc("mem.ld",  C_LD_MEM,  1'b0, 1'b0, 12'd1);
        cyc("mem.wr",  C_WR,      1'b1, 1'b0, 12'd2);
        idle("mem", 12'd2);

        // PUSH_RET
        issue(3'b010);
        cyc("ret.ld", C_LD_RET, 1'b0, 1'b0, 12'd2);
        cyc("ret.wr", C_WR,     1'b1, 1'b0, 12'd3);
        idle("ret", 12'd3);

        // POP_STORE: four cycles, TOS 3 -> 2
        issue(3'b110);
        cyc("pst.rd",  C_NONE,    1'b0, 1'b0, 12'd3);
        cyc("pst.cap", C_POP_CAP, 1'b0, 1'b0, 12'd3);
        cyc("pst.sld", C_ST_LD,   1'b0, 1'b0, 12'd2);
        cyc("pst.swr", C_ST_WR,   1'b1, 1'b0, 12'd2);
        idle("pst", 12'd2);

        // DUP: no TOS change on capture, +1 on push
        issue(3'b100);
        cyc("dup.rd",  C_NONE,    1'b0, 1'b0, 12'd2);
        cyc("dup.cap", C_DUP_CAP, 1'b0, 1'b0, 12'd2);
        cyc("dup.ld",  C_LD_DUP,  1'b0, 1'b0, 12'd2);
        cyc("dup.wr",  C_WR,      1'b1, 1'b0, 12'd3);
        idle("dup", 12'd3);

        // POP down to empty
        for (int i = 3; i > 0; i--) begin
            issue(3'b101);
            cyc("pop.rd",  C_NONE,    1'b0, 1'b0, 12'(i));
            cyc("pop.cap", C_POP_CAP, 1'b1, 1'b0, 12'(i));
            idle("pop", 12'(i - 1));
        end

        // Underflow: POP, POP_STORE, DUP at empty
        issue(3'b101);
        cyc("uf_pop.err", C_NONE, 1'b1, 1'b1, 12'd0);
        idle("uf_pop", 12'd0);
        issue(3'b110);
        cyc("uf_pst.err", C_NONE, 1'b1, 1'b1, 12'd0);
        idle("uf_pst", 12'd0);
        issue(3'b100);
        cyc("uf_dup.err", C_NONE, 1'b1, 1'b1, 12'd0);
        idle("uf_dup", 12'd0);

        // RESTORE to full, then overflow on PUSH_ARG and DUP
        ret_tos = 12'hFFF;
        issue(3'b111);
        cyc("rst_full", C_RESTORE, 1'b1, 1'b0, 12'd0);
        idle("rst_full", 12'hFFF);
        issue(3'b011);
        cyc("of_arg.err", C_NONE, 1'b1, 1'b1, 12'hFFF);
        idle("of_arg", 12'hFFF);
        issue(3'b100);
        cyc("of_dup.err", C_NONE, 1'b1, 1'b1, 12'hFFF);
        idle("of_dup", 12'hFFF);

        // From full: POP then PUSH_ALU back to full succeeds
        issue(3'b101);
        cyc("full_pop.rd",  C_NONE,    1'b0, 1'b0, 12'hFFF);
        cyc("full_pop.cap", C_POP_CAP, 1'b1, 1'b0, 12'hFFF);
        idle("full_pop", 12'hFFE);
        issue(3'b000);
        cyc("refill.ld", C_LD_ALU, 1'b0, 1'b0, 12'hFFE);
        cyc("refill.wr", C_WR,     1'b1, 1'b0, 12'hFFF);
        idle("refill", 12'hFFF);

        // Reset during MEM_CAP of a PUSH_MEM
        ret_tos = 12'h005;
        issue(3'b111);
        cyc("rst5", C_RESTORE, 1'b1, 1'b0, 12'hFFF);
        idle("rst5", 12'h005);
        issue(3'b001);
        cyc("mr.rd", C_NONE, 1'b0, 1'b0, 12'h005);
        chk("mr.cap_ctrl", 32'(ctrl), 32'(C_MEM_CAP));
        #2;
        reset = 1'b0;
        #1;
        chk("mr.async_ctrl",  32'(ctrl), 32'd0);
        chk("mr.async_done",  32'(done), 32'd0);
        chk("mr.async_err",   32'(err), 32'd0);
        chk("mr.async_tos",   32'(tos_shadow), 32'd0);
        chk("mr.async_rdy",   32'(cmd_ready), 32'd0);
        chk("mr.async_state", 32'(state_dbg), 32'd0);
        tick();
        reset = 1'b1;
        chk("mr.rel_rdy_low", 32'(cmd_ready), 32'd0);
        tick();
        chk("mr.rel_rdy_high", 32'(cmd_ready), 32'd1);
        issue(3'b000);
        cyc("post.ld", C_LD_ALU, 1'b0, 1'b0, 12'd0);
        cyc("post.wr", C_WR,     1'b1, 1'b0, 12'd1);
        idle("post", 12'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
